// File: rtl/fib_scan_ctrl.sv
// Fibonacci-membership scan sequencer: sweeps [lo, hi] through an external detector, one value per clock.
// Latency: start to done is hi-lo+2 cycles, or 1 cycle when lo > hi. No backpressure; start is sampled only in IDLE.
// Optional FIB_SCAN_SELFCHECK_EN adds a sticky mismatch flag against an internal golden Fibonacci table.
module fib_scan_ctrl #(
    parameter bit AUTO_CLEAR = 1'b1,
    parameter bit DONE_PULSE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clr,
    input  logic [3:0]  lo,
    input  logic [3:0]  hi,
    output logic [3:0]  fib_in,
    input  logic        fib_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [4:0]  hit_cnt,
`ifdef FIB_SCAN_SELFCHECK_EN
    output logic        mismatch,
`endif
    output logic [15:0] hit_mask
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t     state;
    logic [3:0] hi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            hi_q     <= 4'd0;
            fib_in   <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            hit_cnt  <= 5'd0;
            hit_mask <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        hi_q   <= hi;
                        fib_in <= lo;
                        err    <= (lo > hi);
                        if (AUTO_CLEAR) begin
                            hit_cnt  <= 5'd0;
                            hit_mask <= 16'd0;
                        end
                        // An empty range skips scanning and reports completion at once.
                        if (lo <= hi) begin
                            state <= S_SCAN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end else if (clr) begin
                        hit_cnt  <= 5'd0;
                        hit_mask <= 16'd0;
                        err      <= 1'b0;
                        done     <= 1'b0;
                    end
                end

                S_SCAN: begin
                    if (fib_out) begin
                        // Saturate so repeated accumulating runs never wrap the count.
                        if (hit_cnt != 5'd16) begin
                            hit_cnt <= hit_cnt + 5'd1;
                        end
                        hit_mask[fib_in] <= 1'b1;
                    end
                    if (fib_in == hi_q) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        fib_in <= fib_in + 4'd1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    if (DONE_PULSE) begin
                        done <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIB_SCAN_SELFCHECK_EN
    localparam logic [15:0] GOLDEN_FIB = 16'h212F;

    logic golden_bit;
    assign golden_bit = GOLDEN_FIB[fib_in];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start || clr) begin
                mismatch <= 1'b0;
            end
        end else if (state == S_SCAN) begin
            if (fib_out != golden_bit) begin
                mismatch <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fib_scan_ctrl.sv
// Self-checking bench for fib_scan_ctrl: table-driven range scans plus hand-written corner sequences.
module tb_fib_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clr;
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic [3:0]  fib_in;
    logic        fib_out;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  hit_cnt;
    logic [15:0] hit_mask;
`ifdef FIB_SCAN_SELFCHECK_EN
    logic        mismatch;
`endif
    logic        kill8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic is_fib(input logic [3:0] v);
        case (v)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Detector model, with an optional fault on value 8.
    assign fib_out = is_fib(fib_in) && !(kill8 && (fib_in == 4'd8));

    fib_scan_ctrl #(
        .AUTO_CLEAR(1'b1),
        .DONE_PULSE(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .clr      (clr),
        .lo       (lo),
        .hi       (hi),
        .fib_in   (fib_in),
        .fib_out  (fib_out),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .hit_cnt  (hit_cnt),
`ifdef FIB_SCAN_SELFCHECK_EN
        .mismatch (mismatch),
`endif
        .hit_mask (hit_mask)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues a start and waits (bounded) for done; optionally pulses start+clr mid-scan.
    task automatic run_scan(input logic [3:0] l, input logic [3:0] h, input int inject_at,
                            output int lat, output int busy_n);
        @(negedge clk);
        lo    = l;
        hi    = h;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat    = 0;
        busy_n = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_n++;
            if (k == inject_at) begin
                lo    = 4'd0;
                hi    = 4'd3;
                start = 1'b1;
                clr   = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            clr   = 1'b0;
        end
    endtask

    typedef struct {
        logic [3:0]  lo;
        logic [3:0]  hi;
        int          exp_cnt;
        logic [15:0] exp_mask;
        logic        exp_err;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        int busy_n;

        vecs[0] = '{4'd0,  4'd15, 7, 16'h212F, 1'b0, 17, 16};
        vecs[1] = '{4'd4,  4'd7,  1, 16'h0020, 1'b0, 5,  4};
        vecs[2] = '{4'd13, 4'd13, 1, 16'h2000, 1'b0, 2,  1};
        vecs[3] = '{4'd9,  4'd3,  0, 16'h0000, 1'b1, 1,  0};
        vecs[4] = '{4'd0,  4'd3,  4, 16'h000F, 1'b0, 5,  4};
        vecs[5] = '{4'd14, 4'd15, 0, 16'h0000, 1'b0, 3,  2};
        vecs[6] = '{4'd8,  4'd8,  1, 16'h0100, 1'b0, 2,  1};
        vecs[7] = '{4'd15, 4'd0,  0, 16'h0000, 1'b1, 1,  0};

        kill8 = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        clr   = 1'b0;
        lo    = 4'd0;
        hi    = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_fib_in", 32'(fib_in), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_err",    32'(err),    32'd0);
        check("rst_cnt",    32'(hit_cnt), 32'd0);
        check("rst_mask",   32'(hit_mask), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_scan(vecs[i].lo, vecs[i].hi, 0, lat, busy_n);
            check($sformatf("v%0d_lat", i),  32'(lat),      32'(vecs[i].exp_lat));
            check($sformatf("v%0d_busy", i), 32'(busy_n),   32'(vecs[i].exp_busy));
            check($sformatf("v%0d_cnt", i),  32'(hit_cnt),  32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_mask", i), 32'(hit_mask), 32'(vecs[i].exp_mask));
            check($sformatf("v%0d_err", i),  32'(err),      32'(vecs[i].exp_err));
            @(negedge clk);
            check($sformatf("v%0d_done_drop", i), 32'(done),     32'd0);
            check($sformatf("v%0d_cnt_hold", i),  32'(hit_cnt),  32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_err_hold", i),  32'(err),      32'(vecs[i].exp_err));
        end

        // clr in IDLE drops the held err.
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_err", 32'(err), 32'd0);

        // clr in IDLE wipes accumulated results.
        run_scan(4'd0, 4'd3, 0, lat, busy_n);
        check("pre_clr_cnt", 32'(hit_cnt), 32'd4);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_cnt",  32'(hit_cnt),  32'd0);
        check("clr_mask", 32'(hit_mask), 32'd0);

        // fib_in walks the range one value per cycle and holds at hi.
        @(negedge clk);
        lo    = 4'd4;
        hi    = 4'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("seq_fib_in_%0d", k), 32'(fib_in), 32'(3 + k));
            check($sformatf("seq_busy_%0d", k),   32'(busy),   32'd1);
            @(negedge clk);
        end
        check("seq_done",      32'(done),   32'd1);
        check("seq_fib_hold",  32'(fib_in), 32'd7);
        check("seq_busy_low",  32'(busy),   32'd0);

        // start and clr during SCAN are ignored.
        run_scan(4'd0, 4'd15, 3, lat, busy_n);
        check("ign_lat",  32'(lat),      32'd17);
        check("ign_cnt",  32'(hit_cnt),  32'd7);
        check("ign_mask", 32'(hit_mask), 32'h212F);

        // Async reset on the third SCAN cycle aborts the run.
        @(negedge clk);
        lo    = 4'd0;
        hi    = 4'd15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_cnt", 32'(hit_cnt), 32'd2);
        rst = 1'b1;
        #1;
        check("arst_busy",   32'(busy),     32'd0);
        check("arst_cnt",    32'(hit_cnt),  32'd0);
        check("arst_mask",   32'(hit_mask), 32'd0);
        check("arst_fib_in", 32'(fib_in),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_scan(4'd2, 4'd3, 0, lat, busy_n);
        check("post_rst_lat",  32'(lat),      32'd3);
        check("post_rst_cnt",  32'(hit_cnt),  32'd2);
        check("post_rst_mask", 32'(hit_mask), 32'h000C);

`ifdef FIB_SCAN_SELFCHECK_EN
        check("sc_clean", 32'(mismatch), 32'd0);
        kill8 = 1'b1;
        run_scan(4'd0, 4'd15, 0, lat, busy_n);
        check("sc_cnt",      32'(hit_cnt),  32'd6);
        check("sc_mask",     32'(hit_mask), 32'h202F);
        check("sc_mismatch", 32'(mismatch), 32'd1);
        kill8 = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("sc_clr", 32'(mismatch), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
